calc_ctrl_seq: RTL and testbench
================================

CALC_CTRL_SEQ -- requirements
Module: calc_ctrl_seq

Interface
REQ-001 SHALL have parameter NUM_OPERANDS, default 2, meaning the number of operands captured per calculation (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of EXEC cycles to wait for alu_done (legal range 4..1023).
REQ-003 SHALL have port clk, input, 1, the system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset reset, asynchronous, active-low.
REQ-005 SHALL have port enter_n, input, 1, the raw active-low Enter key, asynchronous to clk.
REQ-006 SHALL have port clear, input, 1, a synchronous abort that returns the sequencer to IDLE.
REQ-007 SHALL have port alu_done, input, 1, the ALU result-valid pulse.
REQ-008 SHALL have port load_en, output, NUM_OPERANDS, one-hot operand-register load strobes.
REQ-009 SHALL have port load_func, output, 1, the function-select register load strobe.
REQ-010 SHALL have port alu_start, output, 1, the ALU start pulse.
REQ-011 SHALL have port load_out, output, 1, the output/display register load strobe.
REQ-012 SHALL have port sel, output, 1, the display mux select (0 = operand entry, 1 = result).
REQ-013 SHALL have port busy, output, 1, high while in EXEC.
REQ-014 SHALL have port err, output, 1, the sticky ALU-timeout flag.
REQ-015 SHALL have port operand_idx, output, $clog2(NUM_OPERANDS), the index of the operand awaiting entry.

Function
REQ-016 SHALL pass enter_n through a 2-flop synchroniser, then detect a falling edge to produce a 1-cycle enter_pulse; the press-to-pulse latency is 3 clk cycles.
REQ-017 SHALL produce exactly one enter_pulse per press, regardless of how long the key is held low.
REQ-018 SHALL implement the states IDLE, LOAD_OPS, LOAD_FUNC, EXEC and SHOW.
REQ-019 SHALL move from IDLE to LOAD_OPS on enter_pulse and set operand_idx to 0.
REQ-020 SHALL, in LOAD_OPS on enter_pulse, pulse load_en[operand_idx] for 1 cycle and then:
- increment operand_idx if operand_idx < NUM_OPERANDS-1;
- otherwise go to LOAD_FUNC.
REQ-021 SHALL, in LOAD_FUNC on enter_pulse, pulse load_func for 1 cycle and enter EXEC.
REQ-022 SHALL assert alu_start for exactly the first EXEC cycle, clear the timeout counter at that point, and hold busy=1 throughout EXEC.
REQ-023 SHALL, in EXEC on alu_done, pulse load_out for 1 cycle, clear err and go to SHOW.
REQ-024 SHALL, if TIMEOUT EXEC cycles elapse without alu_done, set err, leave load_out low and go to SHOW.
REQ-025 SHALL drive sel=1 only in SHOW.
REQ-026 SHALL, in SHOW on enter_pulse, go directly to LOAD_OPS with operand_idx=0.
REQ-027 SHALL ignore enter_pulse in EXEC and alu_done outside EXEC.
REQ-028 SHALL give alu_done priority when it coincides with the timeout expiry cycle.
REQ-029 SHALL give clear priority over all other events: next state IDLE, operand_idx=0, no strobe issued that cycle, err cleared.
REQ-030 SHALL keep load_en, load_func, alu_start and load_out mutually exclusive and registered (glitch-free).

Reset
REQ-031 SHALL, while reset=0, force state=IDLE, operand_idx=0, synchroniser flops=1, and all outputs to 0, including err.
REQ-032 SHALL, on reset assertion mid-operation (e.g. in EXEC), abort immediately with no further strobes.
REQ-033 SHALL issue no enter_pulse on the first cycle after reset release, even if enter_n is held low.

Structure
REQ-034 SHALL place the state enum and the timeout counter width function in the shared package calc_pkg.
REQ-035 SHALL implement the synchroniser and edge detector as the sub-module key_sync (ports clk, reset, key_n, pulse).

Verification
REQ-036 SHALL cover a full sequence with NUM_OPERANDS=3: 5 presses plus alu_done 2 cycles after alu_start -> load_en 001, 010, 100, then load_func, alu_start, load_out, and sel=1.
REQ-037 SHALL cover a key held low for 50 cycles -> exactly one enter_pulse and one load_en strobe.
REQ-038 SHALL cover no alu_done with TIMEOUT=16 -> err=1 and SHOW at cycle 16 of EXEC, with load_out never asserted.
REQ-039 SHALL cover clear asserted in LOAD_OPS with operand_idx=1 -> IDLE next cycle, operand_idx=0, and no strobe.
REQ-040 SHALL cover reset pulsed low during EXEC -> all outputs 0 asynchronously and IDLE after release.
REQ-041 SHALL cover enter presses during EXEC -> ignored, with the sequence completing normally on alu_done.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package calc_pkg;

   // Sequencer states. The value ordering carries no meaning.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_OPS  = 3'd1,
      LOAD_FUNC = 3'd2,
      EXEC      = 3'd3,
      SHOW      = 3'd4
   } state_t;

   // Width of the EXEC timeout counter. It counts 0..timeout-1, so
   // $clog2(timeout) bits are enough. It never returns less than one bit.
   function automatic int tmo_cnt_width(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/key_sync.sv
// Synchronises a raw active-low key and emits one pulse per press.
// Latency: a press reaches pulse 3 clk cycles after enter_n is first sampled low.
// Backpressure: none. Each press gives one pulse, however long the key is held.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset; every flop returns to the key-released level
//   key_n  raw active-low key, asynchronous to clk
//   pulse  one-cycle registered pulse on each falling edge of key_n
module key_sync (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic sync_prev;

   // sync1/sync2 form the metastability synchroniser. sync_prev holds the
   // previous synchronised level, which lets the edge be detected. Every flop
   // resets to 1 (key released). This blocks a pulse on the first cycle after
   // reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
         pulse     <= 1'b0;
      end else begin
         sync1     <= key_n;
         sync2     <= sync1;
         sync_prev <= sync2;
         pulse     <= sync_prev & ~sync2;
      end
   end

endmodule

// File: rtl/calc_ctrl_seq.sv
// Control sequencer for a calculator: operand entry, function load, ALU run, result show.
// Latency: a strobe appears 1 cycle after the enter pulse that causes it. enter_n to strobe is 4 cycles.
// Backpressure: no flow control. Enter is ignored in EXEC, alu_done is ignored outside EXEC,
// and the ALU is abandoned after TIMEOUT cycles.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-low reset
//   enter_n       raw active-low Enter key
//   clear         synchronous abort to IDLE; it outranks every other event
//   alu_done      ALU result-valid pulse
//   load_en       one-hot operand register load strobes
//   load_func     function-select register load strobe
//   alu_start     ALU start pulse, high in the first EXEC cycle
//   load_out      output/display register load strobe
//   sel           display mux select (1 = result, only in SHOW)
//   busy          high for every EXEC cycle
//   err           sticky ALU timeout flag
//   operand_idx   index of the operand awaiting entry
module calc_ctrl_seq
   import calc_pkg::*;
#(
   parameter int NUM_OPERANDS = 2,
   parameter int TIMEOUT      = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enter_n,
   input  logic                            clear,
   input  logic                            alu_done,
   output logic [NUM_OPERANDS-1:0]         load_en,
   output logic                            load_func,
   output logic                            alu_start,
   output logic                            load_out,
   output logic                            sel,
   output logic                            busy,
   output logic                            err,
   output logic [$clog2(NUM_OPERANDS)-1:0] operand_idx
);

   localparam int IW = $clog2(NUM_OPERANDS);
   localparam int TW = tmo_cnt_width(TIMEOUT);

   localparam logic [IW-1:0]           LAST_IDX  = IW'(NUM_OPERANDS - 1);
   localparam logic [TW-1:0]           TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [NUM_OPERANDS-1:0] ONE_HOT_0 = NUM_OPERANDS'(1);

   logic enter_pulse;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_d;
   logic                    err_d;
   logic [TW-1:0]           tcnt_q, tcnt_d;
   logic                    func_pend_q, func_pend_d;
   logic [NUM_OPERANDS-1:0] load_en_d;
   logic                    load_func_d;
   logic                    alu_start_d;
   logic                    load_out_d;

   key_sync u_key_sync (
      .clk   (clk),
      .reset (reset),
      .key_n (enter_n),
      .pulse (enter_pulse)
   );

   // Next state and next strobes. Every strobe is registered below, so the
   // outputs come straight from flops and cannot glitch.
   //
   // load_func and alu_start must never be high together. With registered
   // outputs, the load_func strobe is already one cycle later than its enter
   // pulse. For that reason LOAD_FUNC holds one extra cycle (func_pend_q) after
   // the load_func strobe is issued. Entry to EXEC and alu_start then happen in
   // the cycle after the load_func strobe.
   always_comb begin
      state_d     = state_q;
      idx_d       = operand_idx;
      err_d       = err;
      tcnt_d      = tcnt_q;
      func_pend_d = func_pend_q;
      load_en_d   = '0;
      load_func_d = 1'b0;
      alu_start_d = 1'b0;
      load_out_d  = 1'b0;

      if (clear) begin
         state_d     = IDLE;
         idx_d       = '0;
         err_d       = 1'b0;
         tcnt_d      = '0;
         func_pend_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enter_pulse) begin
                  state_d = LOAD_OPS;
                  idx_d   = '0;
               end
            end

            LOAD_OPS: begin
               if (enter_pulse) begin
                  load_en_d = ONE_HOT_0 << operand_idx;
                  if (operand_idx == LAST_IDX) begin
                     state_d = LOAD_FUNC;
                  end else begin
                     idx_d = operand_idx + IW'(1);
                  end
               end
            end

            LOAD_FUNC: begin
               if (func_pend_q) begin
                  state_d     = EXEC;
                  alu_start_d = 1'b1;
                  tcnt_d      = '0;
                  func_pend_d = 1'b0;
               end else if (enter_pulse) begin
                  load_func_d = 1'b1;
                  func_pend_d = 1'b1;
               end
            end

            EXEC: begin
               // When alu_done arrives in the last allowed cycle, it takes
               // priority over the timeout.
               if (alu_done) begin
                  load_out_d = 1'b1;
                  err_d      = 1'b0;
                  state_d    = SHOW;
               end else if (tcnt_q == TMO_LAST) begin
                  err_d   = 1'b1;
                  state_d = SHOW;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end

            SHOW: begin
               if (enter_pulse) begin
                  state_d = LOAD_OPS;
                  idx_d   = '0;
               end
            end

            default: begin
               state_d     = IDLE;
               idx_d       = '0;
               func_pend_d = 1'b0;
            end
         endcase
      end
   end

   // sel and busy are registered from the next state. They therefore line up
   // exactly with the state register and reset to 0 along with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         operand_idx <= '0;
         err         <= 1'b0;
         tcnt_q      <= '0;
         func_pend_q <= 1'b0;
         load_en     <= '0;
         load_func   <= 1'b0;
         alu_start   <= 1'b0;
         load_out    <= 1'b0;
         sel         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         operand_idx <= idx_d;
         err         <= err_d;
         tcnt_q      <= tcnt_d;
         func_pend_q <= func_pend_d;
         load_en     <= load_en_d;
         load_func   <= load_func_d;
         alu_start   <= alu_start_d;
         load_out    <= load_out_d;
         sel         <= (state_d == SHOW);
         busy        <= (state_d == EXEC);
      end
   end

   // No two of the datapath strobes may be high in the same cycle.
   strobes_exclusive : assert property (
      @(posedge clk) disable iff (!reset)
      $onehot0({load_en, load_func, alu_start, load_out})
   );

endmodule

// File: tb/tb_calc_ctrl_seq.sv
// Self-checking bench for calc_ctrl_seq with NUM_OPERANDS=3 and TIMEOUT=16.
// Latency: n/a.
// Backpressure: n/a.
module tb_calc_ctrl_seq;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       enter_n  = 1'b1;
   logic       clear    = 1'b0;
   logic       alu_done = 1'b0;
   logic [2:0] load_en;
   logic       load_func, alu_start, load_out, sel, busy, err;
   logic [1:0] operand_idx;

   always #5 clk = ~clk;

   calc_ctrl_seq #(.NUM_OPERANDS(N), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .enter_n     (enter_n),
      .clear       (clear),
      .alu_done    (alu_done),
      .load_en     (load_en),
      .load_func   (load_func),
      .alu_start   (alu_start),
      .load_out    (load_out),
      .sel         (sel),
      .busy        (busy),
      .err         (err),
      .operand_idx (operand_idx)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase of the operation, with the key press history and enter pulses
   // derived from it. The model predicts what the outputs hold after each
   // rising edge.
   localparam int P_IDLE = 0, P_OPS = 1, P_FUNC = 2, P_EXEC = 3, P_SHOW = 4;
   int         ph         = P_IDLE;
   int         op_next    = 0;
   int         exec_age   = 0;
   bit         func_taken = 1'b0;
   bit         m_err      = 1'b0;
   bit  [3:0]  hist       = 4'hF;   // hist[0] is the newest sample of enter_n
   bit         m_pulse    = 1'b0;
   logic [2:0] e_load_en  = 3'b000;
   bit         e_func     = 1'b0;
   bit         e_start    = 1'b0;
   bit         e_out      = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         e_load_en = 3'b000; e_func = 1'b0; e_start = 1'b0; e_out = 1'b0;
         if (!reset) begin
            ph = P_IDLE; op_next = 0; exec_age = 0; func_taken = 1'b0;
            m_err = 1'b0; hist = 4'hF; m_pulse = 1'b0;
         end else begin
            if (clear) begin
               ph = P_IDLE; op_next = 0; m_err = 1'b0; func_taken = 1'b0;
            end else begin
               case (ph)
                  P_IDLE: if (m_pulse) begin ph = P_OPS; op_next = 0; end
                  P_OPS: if (m_pulse) begin
                     e_load_en = 3'(1 << op_next);
                     if (op_next < N - 1) op_next++;
                     else ph = P_FUNC;
                  end
                  P_FUNC: begin
                     if (func_taken) begin
                        func_taken = 1'b0; ph = P_EXEC; e_start = 1'b1; exec_age = 1;
                     end else if (m_pulse) begin
                        e_func = 1'b1; func_taken = 1'b1;
                     end
                  end
                  P_EXEC: begin
                     if (alu_done) begin
                        e_out = 1'b1; m_err = 1'b0; ph = P_SHOW;
                     end else if (exec_age == TMO) begin
                        m_err = 1'b1; ph = P_SHOW;
                     end else begin
                        exec_age++;
                     end
                  end
                  P_SHOW: if (m_pulse) begin ph = P_OPS; op_next = 0; end
                  default: ph = P_IDLE;
               endcase
            end
            // A press becomes visible as a pulse 3 edges after it is first sampled low.
            hist    = {hist[2:0], enter_n};
            m_pulse = (hist[2] == 1'b0) && (hist[3] == 1'b1);
         end
      end
   end

   // ---------------- compare and monitor ----------------
   logic [2:0] en_q[$];
   int n_func = 0, n_start = 0, n_out = 0, n_busy = 0;

   initial begin
      logic [10:0] actv, expv;
      forever begin
         @(negedge clk);
         actv = {load_en, load_func, alu_start, load_out, sel, busy, err, operand_idx};
         expv = {e_load_en, e_func, e_start, e_out, (ph == P_SHOW), (ph == P_EXEC),
                 m_err, 2'(op_next)};
         chk("outputs{en,func,start,out,sel,busy,err,idx}", int'(actv), int'(expv));
         if (reset) begin
            if (load_en != 3'b000) en_q.push_back(load_en);
            if (load_func) n_func++;
            if (alu_start) n_start++;
            if (load_out)  n_out++;
            if (busy)      n_busy++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic press(input int hold, input int gap);
      enter_n = 1'b0;
      repeat (hold) tick();
      enter_n = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic clear_mon();
      en_q.delete();
      n_func = 0; n_start = 0; n_out = 0; n_busy = 0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!alu_start && n < 40) begin
         tick();
         n++;
      end
      chk("alu_start_seen", int'(alu_start), 1);
   endtask

   // From IDLE or SHOW: one press to reach LOAD_OPS, N operand presses, then the function press.
   task automatic run_to_exec();
      repeat (N + 1) press(2, 6);
      press(2, 0);
      wait_start();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state.
      repeat (3) tick();
      chk("reset_outputs", int'({load_en, load_func, alu_start, load_out, sel, busy, err}), 0);
      chk("reset_idx", int'(operand_idx), 0);
      reset = 1'b1;
      repeat (2) tick();

      // Full sequence: 5 presses, alu_done 2 cycles after alu_start.
      clear_mon();
      run_to_exec();
      repeat (2) tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      repeat (4) tick();
      chk("full_strobe_count", en_q.size(), 3);
      if (en_q.size() == 3) begin
         chk("full_load_en0", int'(en_q[0]), 1);
         chk("full_load_en1", int'(en_q[1]), 2);
         chk("full_load_en2", int'(en_q[2]), 4);
      end
      chk("full_load_func", n_func, 1);
      chk("full_alu_start", n_start, 1);
      chk("full_load_out", n_out, 1);
      chk("full_busy_cycles", n_busy, 3);
      chk("full_sel", int'(sel), 1);
      chk("full_idx", int'(operand_idx), 2);

      // SHOW -> LOAD_OPS, then a key held for 50 cycles loads exactly one operand.
      press(1, 6);
      clear_mon();
      press(50, 6);
      chk("held_strobe_count", en_q.size(), 1);
      if (en_q.size() == 1) chk("held_load_en", int'(en_q[0]), 1);
      chk("held_idx", int'(operand_idx), 1);

      // Clear in LOAD_OPS with idx=1, in the same cycle as an enter pulse.
      clear_mon();
      enter_n = 1'b0;
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      enter_n = 1'b1;
      chk("clear_idx", int'(operand_idx), 0);
      repeat (6) tick();
      chk("clear_no_strobe", en_q.size(), 0);

      // Timeout: alu_done never arrives.
      clear_mon();
      run_to_exec();
      repeat (25) tick();
      chk("tmo_busy_cycles", n_busy, 16);
      chk("tmo_load_out", n_out, 0);
      chk("tmo_err", int'(err), 1);
      chk("tmo_sel", int'(sel), 1);

      // alu_done in the last allowed EXEC cycle wins over the timeout and clears err.
      clear_mon();
      run_to_exec();
      repeat (15) tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      repeat (4) tick();
      chk("prio_load_out", n_out, 1);
      chk("prio_err", int'(err), 0);
      chk("prio_busy_cycles", n_busy, 16);

      // Enter during EXEC is ignored, and the run completes on alu_done.
      clear_mon();
      run_to_exec();
      press(1, 0);
      repeat (7) tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      repeat (6) tick();
      chk("exec_enter_strobes", en_q.size(), 3);
      chk("exec_enter_busy", n_busy, 9);
      chk("exec_enter_load_out", n_out, 1);
      chk("exec_enter_sel", int'(sel), 1);

      // Asynchronous reset in EXEC, released with enter_n held low.
      clear_mon();
      run_to_exec();
      repeat (2) tick();
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outputs",
          int'({load_en, load_func, alu_start, load_out, sel, busy, err, operand_idx}), 0);
      enter_n = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (6) tick();
      enter_n = 1'b1;
      repeat (4) tick();
      clear_mon();
      press(2, 6);
      chk("post_reset_strobes", en_q.size(), 1);
      if (en_q.size() == 1) chk("post_reset_load_en", int'(en_q[0]), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
